timer_epoch_ctrl: RTL and testbench

Programmable epoch timer that sits directly downstream of the 4-bit ripple counter and consumes its terminal-count output `tc`. Each rising edge of `tc` is one epoch tick. The block counts ticks down from a software reload value and raises a sticky interrupt on expiry, in one-shot or periodic mode. Because `tc` comes from a ripple chain, this block synchronises it into its own clock domain before using it.

---
 rtl/timer_pkg.sv | 14 +
 rtl/tc_sync_edge.sv | 26 ++
 rtl/timer_epoch_ctrl.sv | 130 +++++++++++++
 tb/tb_timer_epoch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the epoch timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_e;

    localparam int   EPOCH_W_DEF   = 8;
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tc_sync_edge.sv
// Brings the ripple-counter terminal count into clk and turns each rising
// edge into a single-cycle pulse.
module tc_sync_edge (
    input  logic clk,
    input  logic clr,
    input  logic async_in,
    output logic rise
);

    logic sync1, sync2, sync3;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

endmodule

// File: rtl/timer_epoch_ctrl.sv
// Epoch timer counting tc ticks down from a reload value; sticky irq on expiry.
// Define TIMER_EPOCH_OVF_EN to build the overrun flag; otherwise ovf is tied 0.
//
// state | meaning
// IDLE  | stopped, epoch = 0
// RUN   | counting ticks, busy = 1
// DONE  | one-shot expired, waiting for ack or restart
module timer_epoch_ctrl
    import timer_pkg::*;
#(
    parameter int EPOCH_W = EPOCH_W_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               tc_in,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [EPOCH_W-1:0] reload,
    input  logic               irq_ack,
    output logic               irq,
    output logic               ovf,
    output logic               busy,
    output logic [EPOCH_W-1:0] epoch
);

    timer_state_e state;
    logic         mode_q;
    logic         tick;
    logic         reload_nz;
    logic         expire;

    tc_sync_edge u_tc_sync (
        .clk      (clk),
        .clr      (clr),
        .async_in (tc_in),
        .rise     (tick)
    );

    assign reload_nz = (reload != '0);
    // stop and start outrank a tick, so an expiry only counts when neither is present
    assign expire = (state == RUN) && !stop && !start && tick && (epoch == EPOCH_W'(1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            epoch  <= '0;
            irq    <= 1'b0;
            busy   <= 1'b0;
            mode_q <= MODE_ONESHOT;
        end else begin
            if (expire)
                irq <= 1'b1;
            else if (irq_ack)
                irq <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && reload_nz) begin
                        epoch  <= reload;
                        mode_q <= mode;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        epoch <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (start) begin
                        if (reload_nz) begin
                            epoch  <= reload;
                            mode_q <= mode;
                        end else begin
                            epoch <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (tick) begin
                        if (epoch > EPOCH_W'(1)) begin
                            epoch <= epoch - EPOCH_W'(1);
                        end else if (epoch == EPOCH_W'(1)) begin
                            if (mode_q == MODE_PERIODIC && reload_nz) begin
                                epoch <= reload;
                            end else begin
                                epoch <= '0;
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    if (start && reload_nz) begin
                        epoch  <= reload;
                        mode_q <= mode;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end else if (irq_ack || !irq) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    epoch <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TIMER_EPOCH_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            ovf_q <= 1'b0;
        else if (expire && irq)
            ovf_q <= 1'b1;
        else if (irq_ack)
            ovf_q <= 1'b0;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_timer_epoch_ctrl.sv
// Directed bench for timer_epoch_ctrl: a per-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_timer_epoch_ctrl;

`ifdef TIMER_EPOCH_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       tc_in;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] reload;
    logic       irq_ack;
    logic       irq;
    logic       ovf;
    logic       busy;
    logic [7:0] epoch;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       tc;
        logic       st;
        logic       sp;
        logic       md;
        logic [7:0] rl;
        logic       ack;
        logic       e_irq;
        logic       e_busy;
        logic [7:0] e_epoch;
    } vec_t;

    vec_t vecs[$];

    timer_epoch_ctrl #(.EPOCH_W(8)) dut (
        .clk     (clk),
        .clr     (clr),
        .tc_in   (tc_in),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .reload  (reload),
        .irq_ack (irq_ack),
        .irq     (irq),
        .ovf     (ovf),
        .busy    (busy),
        .epoch   (epoch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_irq, input logic e_ovf,
                             input logic e_busy, input logic [7:0] e_epoch);
        check({tag, ".irq"},   int'(irq),   int'(e_irq));
        check({tag, ".ovf"},   int'(ovf),   int'(e_ovf));
        check({tag, ".busy"},  int'(busy),  int'(e_busy));
        check({tag, ".epoch"}, int'(epoch), int'(e_epoch));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tc_pulse();
        tc_in = 1'b1;
        repeat (3) step();
        tc_in = 1'b0;
        repeat (3) step();
    endtask

    task automatic add(input logic tc, input logic st, input logic sp, input logic md,
                       input logic [7:0] rl, input logic ack,
                       input logic e_irq, input logic e_busy, input logic [7:0] e_epoch);
        vec_t v;
        v.tc = tc; v.st = st; v.sp = sp; v.md = md; v.rl = rl; v.ack = ack;
        v.e_irq = e_irq; v.e_busy = e_busy; v.e_epoch = e_epoch;
        vecs.push_back(v);
    endtask

    initial begin
        //   tc st sp md rl  ack   irq busy epoch
        add(0, 1, 0, 0, 3, 0,    0, 1, 3);
        add(1, 0, 0, 0, 3, 0,    0, 1, 3);
        add(1, 0, 0, 0, 3, 0,    0, 1, 3);
        add(1, 0, 0, 0, 3, 0,    0, 1, 2);
        add(0, 0, 0, 0, 3, 0,    0, 1, 2);
        add(0, 0, 0, 0, 3, 0,    0, 1, 2);
        add(0, 0, 0, 0, 3, 0,    0, 1, 2);
        add(1, 0, 0, 0, 3, 0,    0, 1, 2);
        add(1, 0, 0, 0, 3, 0,    0, 1, 2);
        add(1, 0, 0, 0, 3, 0,    0, 1, 1);
        add(0, 0, 0, 0, 3, 0,    0, 1, 1);
        add(0, 0, 0, 0, 3, 0,    0, 1, 1);
        add(1, 0, 0, 0, 3, 0,    0, 1, 1);
        add(1, 0, 0, 0, 3, 0,    0, 1, 1);
        add(1, 0, 0, 0, 3, 0,    1, 0, 0);
        add(0, 0, 0, 0, 3, 0,    1, 0, 0);
        add(0, 1, 0, 0, 2, 0,    1, 1, 2);
        add(0, 0, 0, 0, 2, 1,    0, 1, 2);
        add(0, 0, 1, 0, 2, 0,    0, 0, 0);
        add(0, 0, 0, 0, 2, 0,    0, 0, 0);
        add(1, 0, 0, 0, 2, 0,    0, 0, 0);
        add(1, 0, 0, 0, 2, 0,    0, 0, 0);
        add(1, 0, 0, 0, 2, 0,    0, 0, 0);
        add(0, 0, 0, 0, 2, 0,    0, 0, 0);
        add(0, 0, 0, 0, 2, 0,    0, 0, 0);
        add(0, 1, 0, 0, 0, 0,    0, 0, 0);
        add(1, 0, 0, 0, 0, 0,    0, 0, 0);
        add(1, 0, 0, 0, 0, 0,    0, 0, 0);
        add(1, 0, 0, 0, 0, 0,    0, 0, 0);
        add(0, 0, 0, 0, 0, 0,    0, 0, 0);
        add(0, 1, 0, 0, 4, 0,    0, 1, 4);
        add(0, 0, 1, 0, 4, 0,    0, 0, 0);
        add(0, 0, 1, 0, 4, 0,    0, 0, 0);

        clr = 1'b1; tc_in = 1'b0; start = 1'b0; stop = 1'b0;
        mode = 1'b0; reload = 8'd0; irq_ack = 1'b0;
        repeat (2) step();
        check_all("reset", 0, 0, 0, 0);
        clr = 1'b0;
        step();

        foreach (vecs[i]) begin
            tc_in = vecs[i].tc; start = vecs[i].st; stop = vecs[i].sp;
            mode = vecs[i].md; reload = vecs[i].rl; irq_ack = vecs[i].ack;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_irq, 1'b0, vecs[i].e_busy, vecs[i].e_epoch);
        end
        tc_in = 1'b0; start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
        step();

        // reset asserted between edges while running
        mode = 1'b0; reload = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        tc_pulse();
        tc_pulse();
        check_all("midrun_pre", 0, 0, 1, 3);
        #3 clr = 1'b1;
        #1 check_all("midrun_clr", 0, 0, 0, 0);
        #2 clr = 1'b0;
        step();
        tc_pulse();
        check_all("midrun_after", 0, 0, 0, 0);
        reload = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        check_all("midrun_restart", 0, 0, 1, 2);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // periodic reload=2 with overrun
        mode = 1'b1; reload = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        tc_pulse();
        check_all("per_p1", 0, 0, 1, 1);
        tc_pulse();
        check_all("per_p2", 1, 0, 1, 2);
        tc_pulse();
        check_all("per_p3", 1, 0, 1, 1);
        tc_pulse();
        check_all("per_p4", 1, OVF_EN, 1, 2);
        tc_pulse();
        check_all("per_p5", 1, OVF_EN, 1, 1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check_all("per_ack", 0, 0, 1, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_all("per_stop", 0, 0, 0, 0);

        // stop in the same cycle as the expiry tick
        mode = 1'b0; reload = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        tc_in = 1'b1;
        repeat (2) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_all("stopcol", 0, 0, 0, 0);
        tc_in = 1'b0;
        repeat (3) step();
        check_all("stopcol_after", 0, 0, 0, 0);

        // irq_ack coincides with a periodic expiry
        mode = 1'b1; reload = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        tc_pulse();
        check_all("ackcol_first", 1, 0, 1, 1);
        tc_in = 1'b1;
        repeat (2) step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check_all("ackcol_hit", 1, OVF_EN, 1, 1);
        tc_in = 1'b0;
        repeat (3) step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check_all("ackcol_clear", 0, 0, 1, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_all("ackcol_stop", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
